ycr_pipe_div_ctrl: RTL and testbench

//  Front-end between the EXU M-extension decode and the 16-stage radix-4 divider (ycr_pipe_div).

---
 rtl/ycr_div_pkg.sv | 22 ++
 rtl/ycr_pipe_div_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ycr_pipe_div_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ycr_div_pkg.sv
// Shared types for the divide controller: op encoding, FSM states and
// the latency of the radix-4 divider it drives.
package ycr_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } ycr_div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    FAST,
    BUSY,
    RESP,
    DRAIN
  } ycr_div_st_e;

  localparam int YCR_DIV_LAT = 16;

endpackage

// File: rtl/ycr_pipe_div_ctrl.sv
// DIV/DIVU/REM/REMU front-end for ycr_pipe_div: operand tagging, fast paths,
// divider handshake and kill drain. YCR_DIV_REUSE_EN adds a one-entry result cache.
module ycr_pipe_div_ctrl
  import ycr_div_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_vd_i,
  output logic        req_rdy_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  input  logic        kill_i,
  output logic        res_vd_o,
  output logic [31:0] res_data_o,
  input  logic        res_ack_i,
  output logic        div_vd_o,
  output logic [32:0] div_din1_o,
  output logic [32:0] div_din2_o,
  input  logic [31:0] div_quo_i,
  input  logic [31:0] div_rem_i,
  input  logic        div_rdy_i,
  output logic        div_done_o
);

  ycr_div_st_e st_q, st_d;
  ycr_div_op_e op;
  logic        rsel_q, rsel_d;
  logic [32:0] din1_q, din1_d;
  logic [32:0] din2_q, din2_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        vd_q, vd_d;
  logic        done_q, done_d;
  logic        sgn, div0, ovf, acc, hit;
  logic [31:0] hq, hr;

  assign op   = ycr_div_op_e'(req_op_i);
  assign sgn  = (op == DIV) | (op == REM);
  assign div0 = (req_src2_i == 32'h0);
  assign ovf  = sgn & (req_src1_i == 32'h8000_0000)
              & (req_src2_i == 32'hFFFF_FFFF);

  // done_q also holds off the next accept so div_vd_o never
  // lands within one cycle of the previous div_done_o
  assign req_rdy_o  = (st_q == IDLE) & ~done_q;
  assign acc        = req_vd_i & req_rdy_o & ~kill_i;
  assign res_vd_o   = (st_q == RESP);
  assign res_data_o = rsel_q ? r_q : q_q;
  assign div_vd_o   = vd_q;
  assign div_done_o = done_q;
  assign div_din1_o = din1_q;
  assign div_din2_o = din2_q;

`ifdef YCR_DIV_REUSE_EN
  logic        hv_q, hsg_q, sg_q;
  logic [31:0] hs1_q, hs2_q, hq_q, hr_q;
  logic        hclr, hfill;

  assign hit = hv_q & ~div0 & ~ovf & (hsg_q == sgn)
             & (hs1_q == req_src1_i) & (hs2_q == req_src2_i);
  assign hq    = hq_q;
  assign hr    = hr_q;
  assign hclr  = kill_i & ((st_q == BUSY) | (st_q == DRAIN));
  assign hfill = (st_q == BUSY) & div_rdy_i & ~kill_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hv_q  <= 1'b0;
      hsg_q <= 1'b0;
      sg_q  <= 1'b0;
      hs1_q <= '0;
      hs2_q <= '0;
      hq_q  <= '0;
      hr_q  <= '0;
    end else begin
      if (acc) sg_q <= sgn;
      if (hclr) begin
        hv_q <= 1'b0;
      end else if (hfill) begin
        hv_q  <= 1'b1;
        hsg_q <= sg_q;
        hs1_q <= din1_q[31:0];
        hs2_q <= din2_q[31:0];
        hq_q  <= div_quo_i;
        hr_q  <= div_rem_i;
      end
    end
  end
`else
  assign hit = 1'b0;
  assign hq  = '0;
  assign hr  = '0;
`endif

  always_comb begin
    st_d   = st_q;
    rsel_d = rsel_q;
    din1_d = din1_q;
    din2_d = din2_q;
    q_d    = q_q;
    r_d    = r_q;
    vd_d   = 1'b0;
    done_d = div_rdy_i & ((st_q == BUSY) | (st_q == DRAIN));
    unique case (st_q)
      IDLE: if (acc) begin
        rsel_d = req_op_i[1];
        din1_d = {sgn & req_src1_i[31], req_src1_i};
        din2_d = {sgn & req_src2_i[31], req_src2_i};
        st_d   = FAST;
        unique case (1'b1)
          div0: begin
            q_d = 32'hFFFF_FFFF;
            r_d = req_src1_i;
          end
          ovf: begin
            q_d = 32'h8000_0000;
            r_d = 32'h0;
          end
          hit: begin
            q_d = hq;
            r_d = hr;
          end
          default: begin
            st_d = BUSY;
            vd_d = 1'b1;
          end
        endcase
      end
      FAST: st_d = kill_i ? IDLE : RESP;
      BUSY: begin
        if (kill_i) begin
          st_d = div_rdy_i ? IDLE : DRAIN;
        end else if (div_rdy_i) begin
          st_d = RESP;
          q_d  = div_quo_i;
          r_d  = div_rem_i;
        end
      end
      RESP: if (kill_i | res_ack_i) st_d = IDLE;
      DRAIN: if (div_rdy_i) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      rsel_q <= 1'b0;
      din1_q <= '0;
      din2_q <= '0;
      q_q    <= '0;
      r_q    <= '0;
      vd_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rsel_q <= rsel_d;
      din1_q <= din1_d;
      din2_q <= din2_d;
      q_q    <= q_d;
      r_q    <= r_d;
      vd_q   <= vd_d;
      done_q <= done_d;
    end
  end

  a_rdy_in_flight: assert property (@(posedge clk) disable iff (!rstn)
    div_rdy_i |-> ((st_q == BUSY) || (st_q == DRAIN)));

endmodule

// File: tb/tb_ycr_pipe_div_ctrl.sv
// Scoreboard bench for ycr_pipe_div_ctrl with a behavioural 18-cycle divider.
// Build with YCR_DIV_REUSE_EN to exercise the result cache expectations.
module tb_ycr_pipe_div_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_vd_i = 1'b0;
  logic        req_rdy_o;
  logic [1:0]  req_op_i = 2'b00;
  logic [31:0] req_src1_i = '0;
  logic [31:0] req_src2_i = '0;
  logic        kill_i = 1'b0;
  logic        res_vd_o;
  logic [31:0] res_data_o;
  logic        res_ack_i = 1'b0;
  logic        div_vd_o;
  logic [32:0] div_din1_o;
  logic [32:0] div_din2_o;
  logic [31:0] div_quo_i = '0;
  logic [31:0] div_rem_i = '0;
  logic        div_rdy_i = 1'b0;
  logic        div_done_o;

  ycr_pipe_div_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_vd_i   (req_vd_i),
    .req_rdy_o  (req_rdy_o),
    .req_op_i   (req_op_i),
    .req_src1_i (req_src1_i),
    .req_src2_i (req_src2_i),
    .kill_i     (kill_i),
    .res_vd_o   (res_vd_o),
    .res_data_o (res_data_o),
    .res_ack_i  (res_ack_i),
    .div_vd_o   (div_vd_o),
    .div_din1_o (div_din1_o),
    .div_din2_o (div_din2_o),
    .div_quo_i  (div_quo_i),
    .div_rem_i  (div_rem_i),
    .div_rdy_i  (div_rdy_i),
    .div_done_o (div_done_o)
  );

  always #5 clk = ~clk;

`ifdef YCR_DIV_REUSE_EN
  localparam int LR = 2;
  localparam int VR = 0;
`else
  localparam int LR = 20;
  localparam int VR = 1;
`endif

  int errs = 0;
  int chks = 0;
  int vd_cnt = 0;
  int done_cnt = 0;
  int vd_dbl = 0;
  int done_dbl = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // divider model: result-ready 18 cycles after the data_valid cycle
  logic        pend = 1'b0;
  int          dcnt = 0;
  logic        prev_vd = 1'b0;
  logic        prev_done = 1'b0;
  logic signed [63:0] ma, mb;
  logic [31:0] mq, mr;

  always @(negedge clk) begin
    div_rdy_i = 1'b0;
    if (pend) begin
      dcnt++;
      if (dcnt == 18) begin
        div_rdy_i = 1'b1;
        div_quo_i = mq;
        div_rem_i = mr;
        pend = 1'b0;
      end
    end
    if (div_vd_o) begin
      vd_cnt++;
      if (prev_vd) vd_dbl++;
      ma = {{31{div_din1_o[32]}}, div_din1_o};
      mb = {{31{div_din2_o[32]}}, div_din2_o};
      mq = 32'(ma / mb);
      mr = 32'(ma % mb);
      pend = 1'b1;
      dcnt = 0;
    end
    if (div_done_o) begin
      done_cnt++;
      if (prev_done) done_dbl++;
    end
    prev_vd = div_vd_o;
    prev_done = div_done_o;
  end

  task automatic run(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input int vds);
    int k;
    int v0;
    k = 0;
    while (!req_rdy_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_rdy", req_rdy_o, 1);
    exp_q.push_back(ref_res(op, a, b));
    lat_q.push_back(lat);
    v0 = vd_cnt;
    req_vd_i = 1'b1;
    req_op_i = op;
    req_src1_i = a;
    req_src2_i = b;
    @(negedge clk);
    req_vd_i = 1'b0;
    k = 1;
    while (!res_vd_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("res_vd", res_vd_o, 1);
    if (res_vd_o) begin
      check("res_data", res_data_o, exp_q.pop_front());
      check("res_lat", k, lat_q.pop_front());
    end else begin
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
    end
    check("div_vd_n", vd_cnt - v0, vds);
    res_ack_i = 1'b1;
    @(negedge clk);
    res_ack_i = 1'b0;
    check("res_drop", res_vd_o, 0);
  endtask

  initial begin
    int v0, d0, resv, rdyb;
    logic rdy20, rdy21;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", req_rdy_o, 1);
    check("rst_res_vd", res_vd_o, 0);
    check("rst_res_data", res_data_o, 0);
    check("rst_div_vd", div_vd_o, 0);
    check("rst_done", div_done_o, 0);
    check("rst_din1", div_din1_o, 0);
    check("rst_din2", div_din2_o, 0);
    rstn = 1'b1;
    @(negedge clk);

    run(2'b00, 32'hFFFF_FFF9, 32'd2, 20, 1);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, LR, VR);
    run(2'b01, 32'd100, 32'd7, 20, 1);
    run(2'b11, 32'd100, 32'd7, LR, VR);
    run(2'b00, 32'd1234, 32'd0, 2, 0);
    run(2'b10, 32'd5, 32'd0, 2, 0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 20, 1);

    // kill five cycles into a divider trip
    v0 = vd_cnt;
    d0 = done_cnt;
    resv = 0;
    rdyb = 0;
    rdy20 = 1'b1;
    rdy21 = 1'b0;
    req_vd_i = 1'b1;
    req_op_i = 2'b00;
    req_src1_i = 32'd100;
    req_src2_i = 32'd7;
    @(negedge clk);
    req_vd_i = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      kill_i = (k == 5);
      if (res_vd_o) resv++;
      if (k >= 6 && k <= 19 && req_rdy_o) rdyb++;
      if (k == 20) rdy20 = req_rdy_o;
      if (k == 21) rdy21 = req_rdy_o;
      @(negedge clk);
    end
    kill_i = 1'b0;
    check("kill_no_res", resv, 0);
    check("kill_rdy_low", rdyb, 0);
    check("kill_done_guard", rdy20, 0);
    check("kill_rdy_back", rdy21, 1);
    check("kill_vd_n", vd_cnt - v0, 1);
    check("kill_done_n", done_cnt - d0, 1);

    // kill together with ack while a fast result is pending
    req_vd_i = 1'b1;
    req_op_i = 2'b00;
    req_src1_i = 32'd1234;
    req_src2_i = 32'd0;
    @(negedge clk);
    req_vd_i = 1'b0;
    @(negedge clk);
    check("fk_res_vd", res_vd_o, 1);
    kill_i = 1'b1;
    res_ack_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    res_ack_i = 1'b0;
    check("fk_res_drop", res_vd_o, 0);
    check("fk_rdy", req_rdy_o, 1);

    run(2'b00, 32'd100, 32'd7, 20, 1);
    run(2'b10, 32'd100, 32'd7, LR, VR);
    run(2'b01, 32'd100, 32'd7, 20, 1);

    repeat (25) @(negedge clk);
    check("vd_single", vd_dbl, 0);
    check("done_single", done_dbl, 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
